// File: rtl/sw1_pkg.sv
// Definitions shared by the SW1 ping-pong initiator and responder engines:
// the FSM encoding, the sequence-counter width and the TID helper.
package sw1_pkg;

    localparam int SW1_CNT_W = 21;
    // Only the low byte of the TID carries the instance ID
    localparam int SW1_TID_LO_W = 8;

    typedef enum logic [2:0] {
        SW1_IDLE     = 3'd0,
        SW1_POLL_REQ = 3'd1,
        SW1_POLL_RSP = 3'd2,
        SW1_GAP      = 3'd3,
        SW1_ACK_REQ  = 3'd4,
        SW1_ACK_RSP  = 3'd5,
        SW1_DONE     = 3'd6
    } sw1_pong_state_e;

    function automatic logic [15:0] sw1_tid(input logic [31:0] instance_id);
        return {8'h00, instance_id[SW1_TID_LO_W-1:0]};
    endfunction

endpackage

// File: rtl/test_sw1_pong_if.sv
// Read/write arbiter port bundle: master is the test engine, slave is the arbiter.
interface sw1_arb_if #(
    parameter int ADDR_LMT = 20
);
    import sw1_pkg::*;

    logic [ADDR_LMT-1:0]  s22ab_RdAddr;
    logic [15:0]          s22ab_RdTID;
    logic                 s22ab_RdEn;
    logic                 ab2s2_RdSent;
    logic                 ab2s2_RdRspValid;
    logic [15:0]          ab2s2_RdRsp;
    logic [511:0]         ab2s2_RdData;

    logic [ADDR_LMT-1:0]  s22ab_WrAddr;
    logic [15:0]          s22ab_WrTID;
    logic [SW1_CNT_W-1:0] s22ab_WrDin;
    logic                 s22ab_WrEn;
    logic                 ab2s2_WrSent;
    logic                 ab2s2_WrAlmFull;
    logic                 ab2s2_WrRspValid;
    logic [ADDR_LMT-1:0]  ab2s2_WrRspAddr;

    modport master (
        output s22ab_RdAddr, s22ab_RdTID, s22ab_RdEn,
        input  ab2s2_RdSent, ab2s2_RdRspValid, ab2s2_RdRsp, ab2s2_RdData,
        output s22ab_WrAddr, s22ab_WrTID, s22ab_WrDin, s22ab_WrEn,
        input  ab2s2_WrSent, ab2s2_WrAlmFull, ab2s2_WrRspValid, ab2s2_WrRspAddr
    );

    modport slave (
        input  s22ab_RdAddr, s22ab_RdTID, s22ab_RdEn,
        output ab2s2_RdSent, ab2s2_RdRspValid, ab2s2_RdRsp, ab2s2_RdData,
        input  s22ab_WrAddr, s22ab_WrTID, s22ab_WrDin, s22ab_WrEn,
        output ab2s2_WrSent, ab2s2_WrAlmFull, ab2s2_WrRspValid, ab2s2_WrRspAddr
    );

endinterface

// File: rtl/sw1_poll_gap_timer.sv
// Loadable down-counter that spaces out re-polls; done is high while the count is zero.
module sw1_poll_gap_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/test_sw1_pong.sv
// SW1 ping-pong responder: polls the flag line for the next sequence value,
// echoes each match to the ack line, and reports completion after N round trips.
module test_sw1_pong
    import sw1_pkg::*;
#(
    parameter int ADDR_LMT = 20,
    parameter int MDATA    = 14,
    parameter int INSTANCE = 32,
    parameter int POLL_GAP = 4
) (
    input  logic                 Clk_400,
    input  logic                 test_Resetb,
    input  logic                 re2xy_go,
    input  logic [SW1_CNT_W-1:0] re2xy_Numrepeat_sw,
    input  logic [15:0]          flag_Addr,
    input  logic [15:0]          ack_Addr,
    sw1_arb_if.master            arb,
    output logic                 s22ab_TestCmp,
    output logic                 s22ab_Err,
    output logic [31:0]          s22ab_PollCnt
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

    sw1_pong_state_e      r_state;
    logic [SW1_CNT_W-1:0] r_expect;
    logic [SW1_CNT_W-1:0] r_wr_din;
    logic                 r_test_cmp;
    logic                 r_err;
    logic [31:0]          r_poll_cnt;

    logic [15:0]          w_tid;
    logic [SW1_CNT_W-1:0] w_rd_data;
    logic                 w_rd_rsp_hit;
    logic                 w_wr_rsp_hit;
    logic                 w_rd_match;
    logic                 w_gap_load;
    logic                 w_gap_done;
    logic                 w_unused;

    assign w_tid        = sw1_tid(32'(INSTANCE));
    assign w_rd_data    = arb.ab2s2_RdData[SW1_CNT_W-1:0];
    assign w_rd_rsp_hit = arb.ab2s2_RdRspValid &&
                          (arb.ab2s2_RdRsp[SW1_TID_LO_W-1:0] == w_tid[SW1_TID_LO_W-1:0]);
    assign w_wr_rsp_hit = arb.ab2s2_WrRspValid &&
                          (arb.ab2s2_WrRspAddr == ADDR_LMT'(ack_Addr));
    assign w_rd_match   = (w_rd_data == r_expect);
    assign w_gap_load   = (r_state == SW1_POLL_RSP) && w_rd_rsp_hit && !w_rd_match;

    assign w_unused = ^{1'b0, arb.ab2s2_RdData[511:SW1_CNT_W],
                        arb.ab2s2_RdRsp[15:SW1_TID_LO_W], 32'(MDATA)};

    sw1_poll_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .i_clk      (Clk_400),
        .i_rst_n    (test_Resetb),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (r_state == SW1_GAP),
        .o_done     (w_gap_done)
    );

    always_ff @(posedge Clk_400 or negedge test_Resetb) begin
        if (!test_Resetb) begin
            r_state    <= SW1_IDLE;
            r_expect   <= '0;
            r_wr_din   <= '0;
            r_test_cmp <= 1'b0;
            r_err      <= 1'b0;
            r_poll_cnt <= '0;
        end else begin
            case (r_state)
                SW1_IDLE: begin
                    if (re2xy_go) begin
                        if (re2xy_Numrepeat_sw != '0) begin
                            r_expect <= SW1_CNT_W'(1);
                            r_state  <= SW1_POLL_REQ;
                        end else begin
                            r_test_cmp <= 1'b1;
                            r_state    <= SW1_DONE;
                        end
                    end
                end
                SW1_POLL_REQ: begin
                    if (arb.ab2s2_RdSent) begin
                        r_poll_cnt <= r_poll_cnt + 32'd1;
                        r_state    <= SW1_POLL_RSP;
                    end
                end
                SW1_POLL_RSP: begin
                    if (w_rd_rsp_hit) begin
                        if (w_rd_match) begin
                            r_wr_din <= w_rd_data;
                            r_state  <= SW1_ACK_REQ;
                        end else begin
                            // A value ahead of expect means the initiator skipped one
                            if (w_rd_data > r_expect) begin
                                r_err <= 1'b1;
                            end
                            r_state <= (POLL_GAP == 0) ? SW1_POLL_REQ : SW1_GAP;
                        end
                    end
                end
                SW1_GAP: begin
                    if (w_gap_done) begin
                        r_state <= SW1_POLL_REQ;
                    end
                end
                SW1_ACK_REQ: begin
                    if (arb.ab2s2_WrSent) begin
                        r_state <= SW1_ACK_RSP;
                    end
                end
                SW1_ACK_RSP: begin
                    if (w_wr_rsp_hit) begin
                        if (r_expect == re2xy_Numrepeat_sw) begin
                            r_test_cmp <= 1'b1;
                            r_state    <= SW1_DONE;
                        end else begin
                            r_expect <= r_expect + SW1_CNT_W'(1);
                            r_state  <= SW1_POLL_REQ;
                        end
                    end
                end
                SW1_DONE: begin
                    r_test_cmp <= 1'b1;
                end
                default: begin
                    r_state <= SW1_IDLE;
                end
            endcase
        end
    end

    // Enables drop in the same cycle as Sent so each accept yields one request
    assign arb.s22ab_RdEn   = (r_state == SW1_POLL_REQ) && !arb.ab2s2_RdSent;
    assign arb.s22ab_WrEn   = (r_state == SW1_ACK_REQ) && !arb.ab2s2_WrAlmFull &&
                              !arb.ab2s2_WrSent;
    assign arb.s22ab_RdAddr = ADDR_LMT'(flag_Addr);
    assign arb.s22ab_WrAddr = ADDR_LMT'(ack_Addr);
    assign arb.s22ab_RdTID  = w_tid;
    assign arb.s22ab_WrTID  = w_tid;
    assign arb.s22ab_WrDin  = r_wr_din;

    assign s22ab_TestCmp = r_test_cmp;
    assign s22ab_Err     = r_err;
    assign s22ab_PollCnt = r_poll_cnt;

endmodule

// File: tb/tb_test_sw1_pong.sv
// Directed bench for the SW1 responder: the bench plays the arbiter and memory.
module tb_test_sw1_pong;

    localparam int AW = 20;
    localparam logic [15:0] TID     = 16'h0020;
    localparam logic [15:0] FLAG_A  = 16'h1234;
    localparam logic [15:0] ACK_A   = 16'h5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [20:0] nrep = '0;
    logic [15:0] flag_a = FLAG_A;
    logic [15:0] ack_a = ACK_A;
    logic        tc;
    logic        err;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw1_arb_if #(.ADDR_LMT(AW)) arb ();

    test_sw1_pong #(
        .ADDR_LMT (AW),
        .MDATA    (14),
        .INSTANCE (32),
        .POLL_GAP (4)
    ) dut (
        .Clk_400            (clk),
        .test_Resetb        (rst_n),
        .re2xy_go           (go),
        .re2xy_Numrepeat_sw (nrep),
        .flag_Addr          (flag_a),
        .ack_Addr           (ack_a),
        .arb                (arb),
        .s22ab_TestCmp      (tc),
        .s22ab_Err          (err),
        .s22ab_PollCnt      (pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        arb.ab2s2_RdSent     = 1'b0;
        arb.ab2s2_RdRspValid = 1'b0;
        arb.ab2s2_RdRsp      = '0;
        arb.ab2s2_RdData     = '0;
        arb.ab2s2_WrSent     = 1'b0;
        arb.ab2s2_WrAlmFull  = 1'b0;
        arb.ab2s2_WrRspValid = 1'b0;
        arb.ab2s2_WrRspAddr  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        go    = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(input logic [20:0] n);
        nrep = n;
        go   = 1'b1;
        @(negedge clk);
        go   = 1'b0;
    endtask

    // Wait (bounded) for RdEn, accept it, and confirm the enable drops
    task automatic rd_accept(input string tag);
        int n = 0;
        while (arb.s22ab_RdEn !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rden"}, 64'(arb.s22ab_RdEn), 64'(1));
        chk({tag, "_rdaddr"}, 64'(arb.s22ab_RdAddr), 64'(FLAG_A));
        arb.ab2s2_RdSent = 1'b1;
        @(negedge clk);
        arb.ab2s2_RdSent = 1'b0;
        chk({tag, "_rden_drop"}, 64'(arb.s22ab_RdEn), 64'(0));
    endtask

    task automatic rd_respond(input logic [20:0] d, input logic [15:0] tid);
        arb.ab2s2_RdRspValid = 1'b1;
        arb.ab2s2_RdRsp      = tid;
        arb.ab2s2_RdData     = 512'(d);
        @(negedge clk);
        arb.ab2s2_RdRspValid = 1'b0;
        arb.ab2s2_RdData     = '0;
    endtask

    // Cycles from a non-matching response to the next RdEn
    task automatic check_repoll(input string tag);
        int n = 1;
        while (arb.s22ab_RdEn !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'(5));
    endtask

    task automatic wr_accept(input logic [20:0] din, input string tag);
        int n = 0;
        while (arb.s22ab_WrEn !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wren"}, 64'(arb.s22ab_WrEn), 64'(1));
        chk({tag, "_wrdin"}, 64'(arb.s22ab_WrDin), 64'(din));
        chk({tag, "_wraddr"}, 64'(arb.s22ab_WrAddr), 64'(ACK_A));
        arb.ab2s2_WrSent = 1'b1;
        @(negedge clk);
        arb.ab2s2_WrSent = 1'b0;
        chk({tag, "_wren_drop"}, 64'(arb.s22ab_WrEn), 64'(0));
    endtask

    task automatic wr_respond(input logic [AW-1:0] addr);
        arb.ab2s2_WrRspValid = 1'b1;
        arb.ab2s2_WrRspAddr  = addr;
        @(negedge clk);
        arb.ab2s2_WrRspValid = 1'b0;
        arb.ab2s2_WrRspAddr  = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rden", 64'(arb.s22ab_RdEn), 64'(0));
        chk("rst_wren", 64'(arb.s22ab_WrEn), 64'(0));
        chk("rst_testcmp", 64'(tc), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_wrdin", 64'(arb.s22ab_WrDin), 64'(0));
        chk("rst_pollcnt", 64'(pc), 64'(0));
        chk("rst_rdtid", 64'(arb.s22ab_RdTID), 64'(TID));
        chk("rst_wrtid", 64'(arb.s22ab_WrTID), 64'(TID));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three round trips, each matched on the first poll
        start(21'd3);
        chk("t1_go_to_rden", 64'(arb.s22ab_RdEn), 64'(1));
        for (int i = 1; i <= 3; i++) begin
            rd_accept("t1");
            rd_respond(21'(i), TID);
            chk("t1_match_to_wren", 64'(arb.s22ab_WrEn), 64'(1));
            wr_accept(21'(i), "t1");
            chk("t1_testcmp_before", 64'(tc), 64'(0));
            wr_respond(AW'(ACK_A));
            chk("t1_testcmp_after", 64'(tc), 64'(i == 3));
        end
        chk("t1_pollcnt", 64'(pc), 64'(3));
        chk("t1_err", 64'(err), 64'(0));
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        chk("t1_done_no_rden", 64'(arb.s22ab_RdEn), 64'(0));
        chk("t1_done_held", 64'(tc), 64'(1));

        // Data 0, 0, 1 with a gap of 4: each re-poll 5 cycles after its response
        do_reset();
        start(21'd1);
        rd_accept("t2a");
        rd_respond(21'd0, TID);
        chk("t2_gap_no_wren", 64'(arb.s22ab_WrEn), 64'(0));
        check_repoll("t2_repoll_a");
        rd_accept("t2b");
        rd_respond(21'd0, TID);
        check_repoll("t2_repoll_b");
        rd_accept("t2c");
        rd_respond(21'd1, TID);
        wr_accept(21'd1, "t2");
        wr_respond(AW'(ACK_A));
        chk("t2_testcmp", 64'(tc), 64'(1));
        chk("t2_pollcnt", 64'(pc), 64'(3));
        chk("t2_err", 64'(err), 64'(0));

        // Foreign TID ignored; a skip (3 while expecting 2) sets Err
        do_reset();
        start(21'd2);
        rd_accept("t3a");
        rd_respond(21'd1, 16'h0099);
        chk("t3_foreign_tid_wren", 64'(arb.s22ab_WrEn), 64'(0));
        chk("t3_foreign_tid_rden", 64'(arb.s22ab_RdEn), 64'(0));
        rd_respond(21'd1, TID);
        wr_accept(21'd1, "t3a");
        wr_respond(AW'(ACK_A));
        chk("t3_testcmp_mid", 64'(tc), 64'(0));
        rd_accept("t3b");
        rd_respond(21'd3, TID);
        chk("t3_err_set", 64'(err), 64'(1));
        chk("t3_skip_no_wren", 64'(arb.s22ab_WrEn), 64'(0));
        check_repoll("t3_repoll");
        rd_accept("t3c");
        rd_respond(21'd2, TID);
        wr_accept(21'd2, "t3c");
        wr_respond(AW'(ACK_A));
        chk("t3_testcmp", 64'(tc), 64'(1));
        chk("t3_err_sticky", 64'(err), 64'(1));
        chk("t3_pollcnt", 64'(pc), 64'(3));

        // WrAlmFull holds off the echo; foreign write response ignored
        do_reset();
        start(21'd1);
        rd_accept("t4");
        arb.ab2s2_WrAlmFull = 1'b1;
        rd_respond(21'd1, TID);
        for (int k = 0; k < 10; k++) begin
            chk("t4_almfull_wren", 64'(arb.s22ab_WrEn), 64'(0));
            @(negedge clk);
        end
        arb.ab2s2_WrAlmFull = 1'b0;
        #1;
        chk("t4_almfull_drop_wren", 64'(arb.s22ab_WrEn), 64'(1));
        wr_accept(21'd1, "t4");
        wr_respond(AW'(20'h00ABC));
        chk("t4_foreign_wrrsp", 64'(tc), 64'(0));
        wr_respond(AW'(ACK_A));
        chk("t4_testcmp", 64'(tc), 64'(1));

        // Reset while a poll is outstanding, stale response, restart
        do_reset();
        start(21'd2);
        rd_accept("t5a");
        rd_respond(21'd1, TID);
        wr_accept(21'd1, "t5a");
        wr_respond(AW'(ACK_A));
        rd_accept("t5b");
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rden", 64'(arb.s22ab_RdEn), 64'(0));
        chk("t5_rst_wrdin", 64'(arb.s22ab_WrDin), 64'(0));
        chk("t5_rst_pollcnt", 64'(pc), 64'(0));
        chk("t5_rst_testcmp", 64'(tc), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_respond(21'd2, TID);
        chk("t5_stale_rden", 64'(arb.s22ab_RdEn), 64'(0));
        chk("t5_stale_wren", 64'(arb.s22ab_WrEn), 64'(0));
        chk("t5_stale_pollcnt", 64'(pc), 64'(0));
        start(21'd1);
        chk("t5_restart_rden", 64'(arb.s22ab_RdEn), 64'(1));
        rd_accept("t5c");
        rd_respond(21'd1, TID);
        chk("t5_restart_expect1", 64'(arb.s22ab_WrEn), 64'(1));
        wr_accept(21'd1, "t5c");
        wr_respond(AW'(ACK_A));
        chk("t5_testcmp", 64'(tc), 64'(1));
        chk("t5_pollcnt", 64'(pc), 64'(1));

        // Numrepeat = 0 completes at once with no traffic
        do_reset();
        start(21'd0);
        chk("t6_testcmp", 64'(tc), 64'(1));
        for (int k = 0; k < 4; k++) begin
            chk("t6_no_rden", 64'(arb.s22ab_RdEn), 64'(0));
            chk("t6_no_wren", 64'(arb.s22ab_WrEn), 64'(0));
            @(negedge clk);
        end
        chk("t6_pollcnt", 64'(pc), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
